// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB writeback, ID read, debug and counter signals of the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              wbWriteReg;
    logic [ADDR_W-1:0] wbWriteNum;
    logic [DATA_W-1:0] wbWriteData;

    logic              idReadEn1;
    logic [ADDR_W-1:0] idReadNum1;
    logic [DATA_W-1:0] idReadData1;

    logic              idReadEn2;
    logic [ADDR_W-1:0] idReadNum2;
    logic [DATA_W-1:0] idReadData2;

    logic [ADDR_W-1:0] dbgReadNum;
    logic [DATA_W-1:0] dbgReadData;

    logic              cntClear;
    logic [CNT_W-1:0]  wbCount;

    modport master (
        output wbWriteReg, wbWriteNum, wbWriteData,
        output idReadEn1, idReadNum1, idReadEn2, idReadNum2,
        output dbgReadNum, cntClear,
        input  idReadData1, idReadData2, dbgReadData, wbCount
    );

    modport slave (
        input  wbWriteReg, wbWriteNum, wbWriteData,
        input  idReadEn1, idReadNum1, idReadEn2, idReadNum2,
        input  dbgReadNum, cntClear,
        output idReadData1, idReadData2, dbgReadData, wbCount
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - RISC-V x0..x31 register file: write-first ID read ports, debug port, commit counter.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  count;
    logic              commit;

    // Bubbles (wbWriteReg=0 or x0 destination) neither update storage nor count.
    assign commit = bus.wbWriteReg && (bus.wbWriteNum != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.wbWriteNum] <= bus.wbWriteData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (bus.cntClear) begin
            count <= '0;
        end else if (commit) begin
            count <= count + CNT_W'(1);
        end
    end

    assign bus.wbCount = count;

    // Bypass is qualified by commit so a disabled write never leaks its (possibly X) data.
    always_comb begin
        bus.idReadData1 = '0;
        if (bus.idReadEn1 && (bus.idReadNum1 != '0)) begin
            if (commit && (bus.wbWriteNum == bus.idReadNum1)) begin
                bus.idReadData1 = bus.wbWriteData;
            end else begin
                bus.idReadData1 = regs[bus.idReadNum1];
            end
        end
    end

    always_comb begin
        bus.idReadData2 = '0;
        if (bus.idReadEn2 && (bus.idReadNum2 != '0)) begin
            if (commit && (bus.wbWriteNum == bus.idReadNum2)) begin
                bus.idReadData2 = bus.wbWriteData;
            end else begin
                bus.idReadData2 = regs[bus.idReadNum2];
            end
        end
    end

    always_comb begin
        bus.dbgReadData = '0;
        if (bus.dbgReadNum != '0) begin
            bus.dbgReadData = regs[bus.dbgReadNum];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile: vector table, random model compare, corner sequences.
module tb_wb_regfile;

    logic clk;
    logic rst;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    typedef struct {
        logic        we;
        logic [4:0]  wn;
        logic [31:0] wd;
        logic        en1;
        logic [4:0]  n1;
        logic        en2;
        logic [4:0]  n2;
        logic [4:0]  dn;
        logic        clr;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [31:0] ec;
    } vec_t;

    vec_t tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
    endtask

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] num);
        if (!en || num == 5'd0) return 32'h0;
        if (bus.wbWriteReg && bus.wbWriteNum == num) return bus.wbWriteData;
        return m_regs[num];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (bus.wbWriteReg && bus.wbWriteNum != 5'd0) m_regs[bus.wbWriteNum] = bus.wbWriteData;
            if (bus.cntClear) m_cnt = 32'h0;
            else if (bus.wbWriteReg && bus.wbWriteNum != 5'd0) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        check({tag, ".rd1"}, bus.idReadData1, exp_read(bus.idReadEn1, bus.idReadNum1));
        check({tag, ".rd2"}, bus.idReadData2, exp_read(bus.idReadEn2, bus.idReadNum2));
        check({tag, ".dbg"}, bus.dbgReadData, (bus.dbgReadNum == 5'd0) ? 32'h0 : m_regs[bus.dbgReadNum]);
        check({tag, ".cnt"}, bus.wbCount, m_cnt);
    endtask

    task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] wd,
                         input logic en1, input logic [4:0] n1, input logic en2,
                         input logic [4:0] n2, input logic [4:0] dn, input logic clr);
        bus.wbWriteReg  = we;
        bus.wbWriteNum  = wn;
        bus.wbWriteData = wd;
        bus.idReadEn1   = en1;
        bus.idReadNum1  = n1;
        bus.idReadEn2   = en2;
        bus.idReadNum2  = n2;
        bus.dbgReadNum  = dn;
        bus.cntClear    = clr;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();

        tab[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd0, 5'd5, 1'b0, 32'hDEADBEEF, 32'h0,        32'h0,        32'd0};
        tab[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        tab[2] = '{1'b1, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7, 1'b0, 32'h12345678, 32'h12345678, 32'h0,        32'd1};
        tab[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd7, 5'd0, 1'b0, 32'h0,        32'h12345678, 32'h0,        32'd2};
        tab[4] = '{1'b0, 5'd3, 32'hAAAA5555, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 1'b0, 32'h0,        32'h0,        32'h0,        32'd2};
        tab[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 1'b1, 5'd5, 5'd7, 1'b0, 32'h0,        32'hDEADBEEF, 32'h12345678, 32'd2};
        tab[6] = '{1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 5'd3, 1'b1, 5'd5, 5'd3, 1'b1, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0,        32'd2};
        tab[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 1'b0, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'd0};
        tab[8] = '{1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 32'h11111111, 32'h11111111, 32'hDEADBEEF, 32'd0};
        tab[9] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd3, 5'd5, 1'b0, 32'h11111111, 32'hCAFEF00D, 32'h11111111, 32'd1};

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        bus4.wbWriteReg  = 1'b0;
        bus4.wbWriteNum  = 5'd0;
        bus4.wbWriteData = 32'h0;
        bus4.idReadEn1   = 1'b0;
        bus4.idReadNum1  = 5'd0;
        bus4.idReadEn2   = 1'b0;
        bus4.idReadNum2  = 5'd0;
        bus4.dbgReadNum  = 5'd0;
        bus4.cntClear    = 1'b0;

        // Reset for two cycles, then read back every index on all ports.
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i), 5'(i), 1'b0);
            @(negedge clk);
            check($sformatf("reset.rd1[%0d]", i), bus.idReadData1, 32'h0);
            check($sformatf("reset.rd2[%0d]", i), bus.idReadData2, 32'h0);
            check($sformatf("reset.dbg[%0d]", i), bus.dbgReadData, 32'h0);
            tick();
        end
        check("reset.cnt", bus.wbCount, 32'h0);

        for (int k = 0; k < 10; k++) begin
            drive(tab[k].we, tab[k].wn, tab[k].wd, tab[k].en1, tab[k].n1,
                  tab[k].en2, tab[k].n2, tab[k].dn, tab[k].clr);
            @(negedge clk);
            check($sformatf("tab%0d.rd1", k), bus.idReadData1, tab[k].e1);
            check($sformatf("tab%0d.rd2", k), bus.idReadData2, tab[k].e2);
            check($sformatf("tab%0d.dbg", k), bus.dbgReadData, tab[k].ed);
            check($sformatf("tab%0d.cnt", k), bus.wbCount, tab[k].ec);
            tick();
        end

        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  $urandom,
                  ($urandom_range(0, 5) != 0),
                  5'($urandom),
                  ($urandom_range(0, 5) != 0),
                  5'($urandom),
                  5'($urandom),
                  ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) bus.idReadNum1 = bus.wbWriteNum;
            if ($urandom_range(0, 3) == 0) bus.idReadNum2 = bus.wbWriteNum;
            check_model($sformatf("rnd%0d", k));
            tick();
        end

        // Asynchronous reset in the middle of operation.
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 1'b0);
        tick();
        bus.wbWriteReg = 1'b0;
        check_model("async.pre");
        check("async.pre.x9", bus.dbgReadData, 32'h1);
        tick();
        #2 rst = 1'b0;
        #1;
        check("async.rd1", bus.idReadData1, 32'h0);
        check("async.dbg", bus.dbgReadData, 32'h0);
        check("async.cnt", bus.wbCount, 32'h0);
        model_reset();
        drive(1'b1, 5'd9, 32'h3, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 1'b0);
        @(negedge clk);
        check("async.lost.dbg", bus.dbgReadData, 32'h0);
        check("async.bypass", bus.idReadData1, 32'h2);
        tick();
        bus.wbWriteReg = 1'b0;
        check_model("async.post");
        check("async.post.x9", bus.dbgReadData, 32'h2);
        check("async.post.cnt", bus.wbCount, 32'h1);

        // Narrow counter wraps after 16 committed writes.
        @(negedge clk);
        check("wrap.start", 32'(bus4.wbCount), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            bus4.wbWriteReg  = 1'b1;
            bus4.wbWriteNum  = 5'd1;
            bus4.wbWriteData = 32'(k);
            bus4.dbgReadNum  = 5'd1;
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("wrap.cnt%0d", k), 32'(bus4.wbCount), 32'(k % 16));
            check($sformatf("wrap.dbg%0d", k), bus4.dbgReadData, 32'(k));
        end
        bus4.wbWriteReg = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural integer register file (x0..x31) of the 5-stage RISC-V pipeline. It is the receiving end of the MEM/WB writeback interface (wbWriteNum, wbWriteReg, wbWriteData).
- Serves two ID-stage read ports with write-first bypass, plus one debug read port.
- Keeps a committed-write counter for bring-up and performance checks.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W)
CNT_W, 32, width of the committed-write counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
wbWriteReg  input  1  write enable from the MEM/WB stage register
wbWriteNum  input  ADDR_W  destination register index
wbWriteData  input  DATA_W  write data
idReadEn1  input  1  read-port-1 enable
idReadNum1  input  ADDR_W  read-port-1 index
idReadData1  output  DATA_W  read-port-1 data
idReadEn2  input  1  read-port-2 enable
idReadNum2  input  ADDR_W  read-port-2 index
idReadData2  output  DATA_W  read-port-2 data
dbgReadNum  input  ADDR_W  debug read index
dbgReadData  output  DATA_W  debug read data, no bypass
cntClear  input  1  synchronous clear of wbCount
wbCount  output  CNT_W  committed-write counter

Behaviour:
Reset:
- While rst=0, asynchronously clear all registers x0..x31 and wbCount to 0.
- Read outputs follow combinationally from the cleared state, so they read 0.
- Deassertion takes effect on the next rising edge.
- A write presented in the same cycle rst is released is lost only if rst is still 0 at that edge.

Write:
- On the rising edge, if rst=1, wbWriteReg=1 and wbWriteNum!=0: reg[wbWriteNum] <= wbWriteData.
- Writes to x0 are discarded; x0 always reads 0.
- Write latency is 1 cycle to storage.

Read ports 1 and 2 (combinational, zero latency). Priority order:
- En=0 -> data 0.
- Num=0 -> data 0.
- En=1, wbWriteReg=1 and wbWriteNum==Num (Num!=0) -> data = wbWriteData (write-first bypass in the same cycle).
- Otherwise -> reg[Num].
- Both ports may address the same register and both receive the bypass.

Debug port:
- Returns reg[dbgReadNum] only, with no bypass and 0 for index 0.

Counter:
- Each edge with rst=1 is evaluated in this priority order:
  - cntClear=1 -> wbCount <= 0, taking priority over an increment in the same cycle.
  - Else, a committed write (wbWriteReg=1, wbWriteNum!=0) -> wbCount <= wbCount+1.
- wbCount wraps modulo 2**CNT_W: all-ones + 1 = 0.
- Writes to x0 do not count.

Stall/flush interaction:
- None internally. Bubbles arrive from MEM/WB as wbWriteReg=0 / wbWriteNum=0 and are therefore ignored.

X handling:
- wbWriteData is don't-care when wbWriteReg=0.
- Outputs must not go X from a disabled write.

Test Plan:
1. Reset then readback: rst=0 for 2 cycles, release, read all 32 indices on both ports -> every value 0x00000000, wbCount=0.
2. Basic write: write x5=0xDEADBEEF, then on the next cycle read idReadNum1=5 -> 0xDEADBEEF; dbgReadNum=5 -> 0xDEADBEEF; wbCount=1.
3. Bypass: same cycle wbWriteReg=1, Num=7, Data=0x12345678, idReadNum1=7, idReadNum2=7, both enabled -> both ports 0x12345678 before the edge; dbgReadData (Num=7) still shows the old value 0x0 until the edge.
4. x0 and disabled writes:
   - Write x0=0xFFFFFFFF -> reads of x0 give 0, wbCount unchanged.
   - wbWriteReg=0, Num=3, Data=0xAAAA5555 -> x3 unchanged, no bypass.
   - idReadEn1=0 with Num=5 -> 0.
5. Counter edges:
   - Force wbCount to 0xFFFFFFFF via writes, or a reduced CNT_W=4 run of 16 writes -> wraps to 0.
   - cntClear=1 together with a committed write -> wbCount=0 and the register is still written.
6. Async reset mid-operation: write x9=0x1 at edge N, pull rst low between edges N+1 and N+2 -> x9 reads 0 immediately (before the next edge) and wbCount=0; after release, a write to x9=0x2 lands normally.
